pc_predict: RTL and testbench
=============================

# pc_predict

Parametrised next-PC unit with a registered fetch PC, a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits in the IF stage of the pipelined CPU. Each cycle it predicts the next fetch address from the BTB. When the EX stage resolves a control-flow instruction, it computes the actual target using the NPC_* operation codes, detects mispredictions, raises `redirect` to flush IF/ID, and trains the BTB.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `BTB_DEPTH`, 16, BTB entry count; power of two, at least 2; `IDX = log2(BTB_DEPTH)`.
- `RESET_PC`, 32'h0000_0000, fetch address after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold `pc`; used for load-use and IF/ID stall.
- `pc` out XLEN: current fetch address (registered).
- `pred_taken` out 1: BTB predicts taken for `pc`.
- `pred_target` out XLEN: predicted next address; `pc+4` when not taken.
- `ex_valid` in 1: EX holds a valid instruction this cycle.
- `ex_op` in 3: NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JALR.
- `ex_taken` in 1: branch condition result; ignored unless `ex_op`=NPC_BRANCH.
- `ex_pc`, `ex_imm`, `ex_rd1` in XLEN: instruction PC, immediate, rs1 value.
- `ex_pred_taken` in 1, `ex_pred_target` in XLEN: the prediction carried down the pipe with this instruction.
- `redirect` out 1: misprediction; IF/ID must flush.
- `redirect_pc` out XLEN: corrected next address.

## Operation
- Lookup (combinational on `pc`):
  - index = `pc[IDX+1:2]`; tag = `pc[XLEN-1:IDX+2]`.
  - hit = valid & tag match.
  - `pred_taken` = hit & ctr[1].
  - `pred_target` = `pred_taken` ? entry target : `pc+4`.
- Resolution (combinational when `ex_valid`):
  - BRANCH: taken = `ex_taken`, target = `ex_pc+ex_imm`.
  - JUMP: taken = 1, target = `ex_pc+ex_imm`.
  - JALR: taken = 1, target = `(ex_rd1+ex_imm) & ~1`.
  - PLUS4 or any other code: taken = 0.
  - All sums are modulo 2^XLEN; wrap-around is silently allowed.
- Misprediction: actual taken ≠ `ex_pred_taken`, or both taken with target ≠ `ex_pred_target`.
  - `redirect` = `ex_valid` & mispredict.
  - `redirect_pc` = taken ? target : `ex_pc+4`.
- Next-PC priority: `redirect` → `redirect_pc`; else `stall` → hold; else `pred_target`. Redirect overrides stall.
- BTB update at the clock edge, when `ex_valid` and `ex_op`≠PLUS4. Index and tag are taken from `ex_pc`.
  - BRANCH, hit: ctr += taken ? 1 : −1, saturating at 2'b00 and 2'b11. Target rewritten when taken.
  - BRANCH, miss, taken: allocate (overwrite) with ctr=2'b10 and the actual target.
  - BRANCH, miss, not taken: no change.
  - JUMP/JALR: allocate or overwrite with ctr=2'b11 and the actual target.
- Update and lookup to the same index in the same cycle: lookup returns the pre-update contents; there is no write-through.

## Timing
- Reset (async, `rstn`=0): `pc`=`RESET_PC`, all BTB valid bits cleared, counters 2'b00.
  - Consequently `pred_taken`=0, `pred_target`=`RESET_PC+4`, `redirect`=0 (when `ex_valid`=0).
  - Reset asserted mid-operation discards all BTB state immediately.
- `pred_*` and `redirect*` are combinational: zero-cycle latency.
- `pc` updates one edge after the decision; misprediction recovery costs one edge.
- BTB writes become visible to lookup on the cycle after the edge.
- `stall` with `ex_valid`=0 holds `pc` indefinitely; BTB is unchanged.

## Structure
- `ctrl_encode_def.v` holds NPC_* codes (unchanged) plus new defines: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
- Sub-module `btb`: the valid/tag/target/ctr arrays, async-reset valid bits, a one-write-port update and a combinational read port.
- `pc_predict` holds the PC register, resolution, mispredict compare and next-PC mux.

## Test plan
- Reset, then run with no stall and `ex_valid`=0 → `pc` steps 0, 4, 8, 12; `pred_taken`=0 throughout.
- JUMP resolved at `ex_pc`=0x10, `ex_imm`=0x20, `ex_pred_taken`=0 → `redirect`=1, `redirect_pc`=0x30. On the next fetch of 0x10: `pred_taken`=1, `pred_target`=0x30.
- BRANCH at 0x40, `ex_imm`=−8, resolved taken three times → counter 10→11→11, no redirect after the first. Then resolved not taken with `ex_pred_taken`=1 → `redirect_pc`=0x44, counter becomes 10.
- JALR with `ex_rd1`=0x101, `ex_imm`=0 → target 0x100.
- `stall`=1 together with a redirect → `pc` still loads `redirect_pc`.
- `BTB_DEPTH`=4: entries at 0x00 and 0x10 alias to index 0 → the second write evicts the first; a lookup at 0x00 misses.
- Assert `rstn` mid-run → `pc`=`RESET_PC` with no clock edge required, and a previously trained address misses.

Source files
------------

// File: rtl/pc_predict_pkg.sv
// Shared definitions for the next-PC predictor: EX-stage next-PC operation
// codes, the 2-bit direction counter states, and the BTB update kinds.
package pc_predict_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // Saturating direction counter; the upper bit is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // What the BTB should do with the instruction resolving in EX.
    typedef enum logic [1:0] {
        UPD_NONE   = 2'b00,
        UPD_BRANCH = 2'b01,
        UPD_JUMP   = 2'b10
    } upd_kind_e;

    // Step a direction counter toward the resolved outcome, clamping at the ends.
    function automatic ctr_e ctr_step(input ctr_e ctr, input logic taken);
        ctr_e result;
        if (taken) begin
            result = (ctr == CTR_ST) ? CTR_ST : ctr_e'(ctr + 2'd1);
        end else begin
            result = (ctr == CTR_SNT) ? CTR_SNT : ctr_e'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_predict_btb.sv
// Direct-mapped branch target buffer: one combinational read port for the
// fetch lookup and one update port driven by the EX-stage resolution.
// Reads see the contents from before any update on the same edge.
module pc_predict_btb
    import pc_predict_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int IDX   = $clog2(DEPTH),
    parameter int TAGW  = XLEN - IDX - 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [XLEN-1:0] rd_target,
    output ctr_e            rd_ctr,
    input  upd_kind_e       upd_kind,
    input  logic [IDX-1:0]  upd_idx,
    input  logic [TAGW-1:0] upd_tag,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    logic            valid_q  [DEPTH];
    ctr_e            ctr_q    [DEPTH];
    logic [TAGW-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH];

    logic upd_hit;
    logic wr_en;
    logic wr_alloc;
    logic wr_target;
    ctr_e wr_ctr;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Decide whether the entry is trained in place, freshly allocated, or left alone.
    always_comb begin
        wr_en     = 1'b0;
        wr_alloc  = 1'b0;
        wr_target = 1'b0;
        wr_ctr    = CTR_SNT;
        case (upd_kind)
            UPD_BRANCH: begin
                if (upd_hit) begin
                    wr_en     = 1'b1;
                    wr_ctr    = ctr_step(ctr_q[upd_idx], upd_taken);
                    wr_target = upd_taken;
                end else if (upd_taken) begin
                    wr_en     = 1'b1;
                    wr_alloc  = 1'b1;
                    wr_ctr    = CTR_WT;
                    wr_target = 1'b1;
                end
            end
            UPD_JUMP: begin
                wr_en     = 1'b1;
                wr_alloc  = 1'b1;
                wr_ctr    = CTR_ST;
                wr_target = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Valid bits and counters are cleared by reset so every lookup misses afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_SNT;
            end
        end else if (wr_en) begin
            ctr_q[upd_idx] <= wr_ctr;
            if (wr_alloc) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Tags and targets need no reset; they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && wr_alloc) begin
            tag_q[upd_idx] <= upd_tag;
        end
        if (wr_en && wr_target) begin
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_predict.sv
// IF-stage next-PC unit: registered fetch PC, BTB-based prediction, and
// EX-stage resolution that detects mispredictions and trains the BTB.
module pc_predict
    import pc_predict_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rd1,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = XLEN - IDX - 2;

    logic            lk_valid;
    logic [TAGW-1:0] lk_tag;
    logic [XLEN-1:0] lk_target;
    ctr_e            lk_ctr;
    logic            lk_hit;

    logic            act_taken;
    logic [XLEN-1:0] act_target;
    upd_kind_e       act_kind;
    upd_kind_e       btb_kind;
    logic            mispredict;
    logic [XLEN-1:0] next_pc;

    pc_predict_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rstn       (rstn),
        .rd_idx     (pc[IDX+1:2]),
        .rd_valid   (lk_valid),
        .rd_tag     (lk_tag),
        .rd_target  (lk_target),
        .rd_ctr     (lk_ctr),
        .upd_kind   (btb_kind),
        .upd_idx    (ex_pc[IDX+1:2]),
        .upd_tag    (ex_pc[XLEN-1:IDX+2]),
        .upd_taken  (act_taken),
        .upd_target (act_target)
    );

    assign lk_hit      = lk_valid && (lk_tag == pc[XLEN-1:IDX+2]);
    assign pred_taken  = lk_hit && (lk_ctr inside {CTR_WT, CTR_ST});
    assign pred_target = pred_taken ? lk_target : pc + XLEN'(4);

    // Work out the real direction and destination of the instruction in EX.
    always_comb begin
        act_taken  = 1'b0;
        act_target = ex_pc + ex_imm;
        act_kind   = UPD_NONE;
        case (ex_op)
            NPC_BRANCH: begin
                act_taken = ex_taken;
                act_kind  = UPD_BRANCH;
            end
            NPC_JUMP: begin
                act_taken = 1'b1;
                act_kind  = UPD_JUMP;
            end
            NPC_JALR: begin
                act_taken  = 1'b1;
                act_target = (ex_rd1 + ex_imm) & ~XLEN'(1);
                act_kind   = UPD_JUMP;
            end
            default: begin
            end
        endcase
    end

    assign btb_kind    = ex_valid ? act_kind : UPD_NONE;
    assign mispredict  = (act_taken != ex_pred_taken) ||
                         (act_taken && (act_target != ex_pred_target));
    assign redirect    = ex_valid && mispredict;
    assign redirect_pc = act_taken ? act_target : ex_pc + XLEN'(4);

    // A misprediction must win even over a stall, otherwise the flush would be lost.
    always_comb begin
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc;
        end else begin
            next_pc = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict. Two instances (16-entry and 4-entry BTB)
// share one stimulus stream; a behavioural model tracks each one's fetch PC
// and BTB contents using plain address arithmetic.
module tb_pc_predict;
    import pc_predict_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rd1;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic [31:0] pc_a, pred_target_a, redirect_pc_a;
    logic        pred_taken_a, redirect_a;
    logic [31:0] pc_b, pred_target_b, redirect_pc_b;
    logic        pred_taken_b, redirect_b;

    int num_checks = 0;
    int num_fails  = 0;

    // Behavioural model state, [0] = 16-entry instance, [1] = 4-entry instance.
    bit          m_valid [2][16];
    logic [31:0] m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    logic [31:0] m_pc    [2];

    pc_predict #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(RESET_PC)) dut16 (
        .clk(clk), .rstn(rstn), .stall(stall),
        .pc(pc_a), .pred_taken(pred_taken_a), .pred_target(pred_target_a),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd1(ex_rd1),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect_a), .redirect_pc(redirect_pc_a)
    );

    pc_predict #(.XLEN(32), .BTB_DEPTH(4), .RESET_PC(RESET_PC)) dut4 (
        .clk(clk), .rstn(rstn), .stall(stall),
        .pc(pc_b), .pred_taken(pred_taken_b), .pred_target(pred_target_b),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd1(ex_rd1),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: actual %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic int index_of(input int k, input logic [31:0] a);
        return int'((a >> 2) % 32'(depth_of(k)));
    endfunction

    function automatic logic [31:0] tag_of(input int k, input logic [31:0] a);
        return a / (32'd4 * 32'(depth_of(k)));
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RESET_PC;
            for (int i = 0; i < 16; i++) begin
                m_valid[k][i] = 1'b0;
                m_ctr[k][i]   = 0;
            end
        end
    endtask

    task automatic modelLookup(input int k, input logic [31:0] a, output logic taken, output logic [31:0] target);
        int   i;
        logic hit;
        i      = index_of(k, a);
        hit    = m_valid[k][i] && (m_tag[k][i] == tag_of(k, a));
        taken  = hit && (m_ctr[k][i] >= 2);
        target = taken ? m_tgt[k][i] : a + 32'd4;
    endtask

    task automatic resolve(output logic taken, output logic [31:0] target);
        taken  = 1'b0;
        target = ex_pc + 32'd4;
        if (ex_op == NPC_BRANCH) begin
            taken  = ex_taken;
            target = ex_pc + ex_imm;
        end else if (ex_op == NPC_JUMP) begin
            taken  = 1'b1;
            target = ex_pc + ex_imm;
        end else if (ex_op == NPC_JALR) begin
            taken  = 1'b1;
            target = (ex_rd1 + ex_imm) & 32'hFFFF_FFFE;
        end
    endtask

    task automatic modelTrain(input int k, input logic taken, input logic [31:0] target);
        int   i;
        logic hit;
        if (!ex_valid) return;
        i   = index_of(k, ex_pc);
        hit = m_valid[k][i] && (m_tag[k][i] == tag_of(k, ex_pc));
        if (ex_op == NPC_BRANCH) begin
            if (hit) begin
                if (taken) begin
                    m_ctr[k][i] = (m_ctr[k][i] < 3) ? m_ctr[k][i] + 1 : 3;
                    m_tgt[k][i] = target;
                end else begin
                    m_ctr[k][i] = (m_ctr[k][i] > 0) ? m_ctr[k][i] - 1 : 0;
                end
            end else if (taken) begin
                m_valid[k][i] = 1'b1;
                m_tag[k][i]   = tag_of(k, ex_pc);
                m_tgt[k][i]   = target;
                m_ctr[k][i]   = 2;
            end
        end else if (ex_op == NPC_JUMP || ex_op == NPC_JALR) begin
            m_valid[k][i] = 1'b1;
            m_tag[k][i]   = tag_of(k, ex_pc);
            m_tgt[k][i]   = target;
            m_ctr[k][i]   = 3;
        end
    endtask

    // Compare every output of both instances with the model, then advance the model past the next edge.
    task automatic checkCycle();
        logic        act_taken, exp_redirect, p_taken;
        logic [31:0] act_target, exp_rpc, p_target, nxt;
        if (!rstn) modelReset();
        resolve(act_taken, act_target);
        exp_redirect = ex_valid && ((act_taken != ex_pred_taken) ||
                                    (act_taken && act_target != ex_pred_target));
        exp_rpc      = act_taken ? act_target : ex_pc + 32'd4;
        for (int k = 0; k < 2; k++) begin
            modelLookup(k, m_pc[k], p_taken, p_target);
            checkOutput($sformatf("pc%0d", depth_of(k)), (k == 0) ? pc_a : pc_b, m_pc[k]);
            checkOutput($sformatf("pred_taken%0d", depth_of(k)),
                        32'((k == 0) ? pred_taken_a : pred_taken_b), 32'(p_taken));
            checkOutput($sformatf("pred_target%0d", depth_of(k)),
                        (k == 0) ? pred_target_a : pred_target_b, p_target);
            checkOutput($sformatf("redirect%0d", depth_of(k)),
                        32'((k == 0) ? redirect_a : redirect_b), 32'(exp_redirect));
            checkOutput($sformatf("redirect_pc%0d", depth_of(k)),
                        (k == 0) ? redirect_pc_a : redirect_pc_b, exp_rpc);
            if (rstn) begin
                if (exp_redirect)  nxt = exp_rpc;
                else if (stall)    nxt = m_pc[k];
                else               nxt = p_target;
                modelTrain(k, act_taken, act_target);
                m_pc[k] = nxt;
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [2:0] op, input logic tk,
                                 input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rd1,
                                 input logic pt, input logic [31:0] ptg);
        @(negedge clk);
        stall          = s;
        ex_valid       = v;
        ex_op          = op;
        ex_taken       = tk;
        ex_pc          = epc;
        ex_imm         = imm;
        ex_rd1         = rd1;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        #1;
        checkCycle();
    endtask

    task automatic idleCycle(input logic s);
        applyStimulus(s, 1'b0, NPC_PLUS4, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Force a fetch of addr by resolving a plain instruction at addr-4 that claimed to be taken.
    task automatic fetchAt(input logic [31:0] addr);
        applyStimulus(1'b0, 1'b1, NPC_PLUS4, 1'b0, addr - 32'd4, 32'h0, 32'h0, 1'b1, 32'h0);
    endtask

    initial begin
        logic [2:0]  ops [4];
        logic        r_pt;
        logic [31:0] r_ptg, r_pc;
        ops[0] = NPC_PLUS4;
        ops[1] = NPC_BRANCH;
        ops[2] = NPC_JUMP;
        ops[3] = NPC_JALR;

        rstn = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_op = NPC_PLUS4; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_imm = 32'h0; ex_rd1 = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        modelReset();
        #1;
        checkCycle();
        @(posedge clk);
        #1 rstn = 1'b1;

        $display("[TB] sequential fetch after reset");
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            checkOutput("seq_pc", pc_a, 32'(4 * i));
            checkOutput("seq_pred_taken", 32'(pred_taken_a), 32'd0);
        end

        $display("[TB] jump training");
        applyStimulus(1'b0, 1'b1, NPC_JUMP, 1'b0, 32'h10, 32'h20, 32'h0, 1'b0, 32'h0);
        checkOutput("jump_redirect", 32'(redirect_a), 32'd1);
        checkOutput("jump_redirect_pc", redirect_pc_a, 32'h30);
        fetchAt(32'h10);
        idleCycle(1'b0);
        checkOutput("jump_hit_taken", 32'(pred_taken_a), 32'd1);
        checkOutput("jump_hit_target", pred_target_a, 32'h30);

        $display("[TB] branch counter training");
        applyStimulus(1'b0, 1'b1, NPC_BRANCH, 1'b1, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0);
        checkOutput("br_first_redirect", 32'(redirect_a), 32'd1);
        checkOutput("br_first_redirect_pc", redirect_pc_a, 32'h38);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, NPC_BRANCH, 1'b1, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h38);
            checkOutput("br_repeat_redirect", 32'(redirect_a), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, NPC_BRANCH, 1'b0, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h38);
        checkOutput("br_nt_redirect", 32'(redirect_a), 32'd1);
        checkOutput("br_nt_redirect_pc", redirect_pc_a, 32'h44);
        fetchAt(32'h40);
        idleCycle(1'b0);
        checkOutput("br_weak_taken", 32'(pred_taken_a), 32'd1);
        checkOutput("br_weak_target", pred_target_a, 32'h38);
        applyStimulus(1'b0, 1'b1, NPC_BRANCH, 1'b0, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h38);
        fetchAt(32'h40);
        idleCycle(1'b0);
        checkOutput("br_weak_nt_taken", 32'(pred_taken_a), 32'd0);
        checkOutput("br_weak_nt_target", pred_target_a, 32'h44);

        $display("[TB] jalr target alignment");
        applyStimulus(1'b0, 1'b1, NPC_JALR, 1'b0, 32'h50, 32'h0, 32'h101, 1'b0, 32'h0);
        checkOutput("jalr_redirect_pc", redirect_pc_a, 32'h100);

        $display("[TB] redirect overrides stall");
        applyStimulus(1'b1, 1'b1, NPC_JUMP, 1'b0, 32'h60, 32'h40, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b1);
            checkOutput("stall_hold_pc", pc_a, 32'hA0);
        end

        $display("[TB] aliasing in the 4-entry BTB");
        applyStimulus(1'b0, 1'b1, NPC_JUMP, 1'b0, 32'h00, 32'h80, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, NPC_JUMP, 1'b0, 32'h10, 32'h20, 32'h0, 1'b0, 32'h0);
        fetchAt(32'h0);
        idleCycle(1'b0);
        checkOutput("alias_pc", pc_b, 32'h0);
        checkOutput("alias_small_taken", 32'(pred_taken_b), 32'd0);
        checkOutput("alias_small_target", pred_target_b, 32'h4);
        checkOutput("alias_big_taken", 32'(pred_taken_a), 32'd1);
        checkOutput("alias_big_target", pred_target_a, 32'h80);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            r_pc = 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 1) == 1) begin
                modelLookup(0, r_pc, r_pt, r_ptg);
            end else begin
                r_pt  = 1'($urandom_range(0, 1));
                r_ptg = 32'($urandom_range(0, 127)) * 32'd4;
            end
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
                          ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), r_pc,
                          32'($urandom_range(0, 255)) - 32'd128, 32'($urandom_range(0, 511)),
                          r_pt, r_ptg);
        end

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b0, 1'b1, NPC_JUMP, 1'b0, 32'h10, 32'h20, 32'h0, 1'b0, 32'h0);
        #1 rstn = 1'b0;
        #1;
        checkOutput("async_reset_pc16", pc_a, RESET_PC);
        checkOutput("async_reset_pc4", pc_b, RESET_PC);
        stall = 1'b0; ex_valid = 1'b0;
        #1;
        checkCycle();
        @(posedge clk);
        #1 rstn = 1'b1;
        fetchAt(32'h10);
        idleCycle(1'b0);
        checkOutput("post_reset_pc", pc_a, 32'h10);
        checkOutput("post_reset_miss", 32'(pred_taken_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
